// File: rtl/hs_rr_arbiter_pkg.sv
// hs_rr_arbiter shared types and defaults.
// Build option: HS_ARB_FIXED_PRIO_EN selects fixed priority.
package hs_arb_pkg;

  localparam int DW_DEF = 7;

  typedef logic [0:0] state_t;

  localparam state_t S_EMPTY = 1'b0;
  localparam state_t S_FULL  = 1'b1;

endpackage

// File: rtl/hs_rr_arbiter_if.sv
// Upstream request bus and downstream output channel.
// master drives requests; slave is the arbiter.
interface hs_rr_arbiter_if
  import hs_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = DW_DEF
) ();

  localparam int IW = $clog2(N);

  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_src;
  logic            out_ready;

  modport master (
    output req_valid,
    output req_data,
    output out_ready,
    input  req_ready,
    input  out_valid,
    input  out_data,
    input  out_src
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  out_ready,
    output req_ready,
    output out_valid,
    output out_data,
    output out_src
  );

endinterface

// File: rtl/hs_rr_arbiter_rr_pick.sv
// Wrap-around grant search starting at ptr.
// HS_ARB_FIXED_PRIO_EN: search always starts at 0.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  int start;

`ifdef HS_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign start = 0;
`else
  assign start = int'(ptr);
`endif

  // first valid index at or above start, wrapping
  always_comb begin
    int   j;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = start + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/hs_rr_arbiter.sv
// N-to-1 round-robin handshake arbiter, 1-entry out reg.
// HS_ARB_FIXED_PRIO_EN: lowest valid index wins, no ptr.
module hs_rr_arbiter
  import hs_arb_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int DW = DW_DEF,
  localparam int IW = $clog2(N)
) (
  input logic            clk,
  input logic            rst,
  hs_rr_arbiter_if.slave bus
);

  state_t          state_q;
  logic [DW-1:0]   data_q;
  logic [IW-1:0]   src_q;
  logic [IW-1:0]   ptr;
  logic [N-1:0]    grant;
  logic [IW-1:0]   idx;
  logic [DW-1:0]   sel_data;
  logic            can_load;
  logic            load;

  rr_pick #(.N(N)) u_pick (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (idx)
  );

  assign bus.out_valid = (state_q == S_FULL);
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;

  assign can_load = ~bus.out_valid | bus.out_ready;

  // no handshake may complete while reset is held
  assign bus.req_ready = grant & {N{can_load & rst}};
  assign load          = |(bus.req_valid & bus.req_ready);

  // word of the granted requester
  always_comb begin
    sel_data = bus.req_data[int'(idx)*DW +: DW];
  end

`ifdef HS_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  // next search starts just past the last winner
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
    end
  end
`endif

  // output register: load wins over drain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_EMPTY;
      data_q  <= '0;
      src_q   <= '0;
    end else if (load) begin
      state_q <= S_FULL;
      data_q  <= sel_data;
      src_q   <= idx;
    end else if (bus.out_ready) begin
      state_q <= S_EMPTY;
    end
  end

endmodule
